// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit adder reused per clock, LSB nibble first.
// Optional subtract mode (sub port, b inverted, carry forced to 1) enabled by ADDSEQ_SUB_EN.

module four_bit_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_c
);
   assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_c};
endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef ADDSEQ_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] y,
   output logic             c_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);
   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cy;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_y;
   logic             r_c_out;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_sum;
   logic             w_carry;
   logic             w_last;
   logic [WIDTH-1:0] w_b_load;
   logic             w_cy_load;

   assign w_a_nib = r_a[4*r_idx +: 4];
   assign w_b_nib = r_b[4*r_idx +: 4];
   assign w_last  = (r_idx == LAST_IDX);

`ifdef ADDSEQ_SUB_EN
   // Two's-complement subtract: a + ~b + 1; c_out=1 then means no borrow.
   assign w_b_load  = sub ? ~b : b;
   assign w_cy_load = sub ? 1'b1 : c_in;
`else
   assign w_b_load  = b;
   assign w_cy_load = c_in;
`endif

   four_bit_adder u_add (
      .i_a (w_a_nib),
      .i_b (w_b_nib),
      .i_c (r_cy),
      .o_s (w_sum),
      .o_c (w_carry)
   );

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_next = S_RUN;
         S_RUN:   if (w_last)    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cy    <= 1'b0;
         r_idx   <= '0;
         r_y     <= '0;
         r_c_out <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= w_b_load;
                  r_cy  <= w_cy_load;
                  r_idx <= '0;
               end
            end
            S_RUN: begin
               r_y[4*r_idx +: 4] <= w_sum;
               r_cy              <= w_carry;
               if (w_last) r_c_out <= w_carry;
               else        r_idx   <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign y         = r_y;
   assign c_out     = r_c_out;
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table plus handshake,
// backpressure, reset and throughput sequences; subtract vectors under ADDSEQ_SUB_EN.

module tb_nibble_serial_adder;
   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic [WIDTH-1:0] y;
   logic             c_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   int n_cmp  = 0;
   int n_fail = 0;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
`ifdef ADDSEQ_SUB_EN
      .sub       (sub),
`endif
      .y         (y),
      .c_out     (c_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] y;
      logic        cout;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from IDLE and waits for out_valid; result is left in DONE.
   task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic tc, input logic ts, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      a = ta; b = tb_v; c_in = tc; sub = ts;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t vecs[$];
   int   lat;

   initial begin
      logic [15:0] ta [3];
      logic [15:0] tbv[3];
      logic [15:0] texp[3];
      logic        xfer, oxfer;
      int          k, r, last_t;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      #12;
      check("reset_y",         32'(y), 32'h0);
      check("reset_c_out",     32'(c_out), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_busy",      32'(busy), 32'h0);
      check("reset_in_ready",  32'(in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      vecs.push_back('{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
      vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
`ifdef ADDSEQ_SUB_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
      vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         start_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
         check($sformatf("vec%0d_y", i),       32'(y), 32'(vecs[i].y));
         check($sformatf("vec%0d_c_out", i),   32'(c_out), 32'(vecs[i].cout));
         accept();
         check($sformatf("vec%0d_idle", i),    32'({in_ready, out_valid, busy}), 32'b100);
      end

      // Backpressure: hold DONE for 5 cycles while trying to push a new operation.
      start_and_wait(16'h1234, 16'h0FCD, 1'b0, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         a = 16'h5A5A; b = 16'h0F0F; c_in = 1'b1;
         in_valid = 1'b1;
         tick();
         check($sformatf("bp%0d_y", i),     32'(y), 32'h2201);
         check($sformatf("bp%0d_flags", i), 32'({c_out, out_valid, in_ready, busy}), 32'b0101);
      end
      in_valid = 1'b0;
      accept();
      check("bp_release_idle", 32'({in_ready, out_valid, busy}), 32'b100);
      check("bp_release_y",    32'(y), 32'h2201);
      tick();
      check("bp_ignored_input", 32'({in_ready, busy}), 32'b10);

      // Reset two RUN edges into an operation.
      a = 16'hAAAA; b = 16'h5555; c_in = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", 32'({y, c_out, out_valid, busy, in_ready}), 32'({16'h0, 4'b0001}));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_and_wait(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
      check("post_rst_y", 32'({c_out, y}), 32'h0_0002);
      accept();

      // Back-to-back streaming with in_valid and out_ready held high.
      ta[0] = 16'h1111; tbv[0] = 16'h2222; texp[0] = 16'h3333;
      ta[1] = 16'hF000; tbv[1] = 16'h1000; texp[1] = 16'h0000;
      ta[2] = 16'h0FFF; tbv[2] = 16'h0001; texp[2] = 16'h1000;
      k = 0; r = 0; last_t = -1;
      a = ta[0]; b = tbv[0]; c_in = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && r < 3; cyc++) begin
         xfer  = in_valid && in_ready;
         oxfer = out_valid && out_ready;
         if (oxfer) begin
            check($sformatf("stream%0d_y", r), 32'(y), 32'(texp[r]));
            r++;
         end
         if (xfer) begin
            if (k > 0) check($sformatf("stream%0d_period", k), 32'(cyc - last_t), 32'd6);
            last_t = cyc;
            k++;
         end
         tick();
         if (xfer) begin
            if (k < 3) begin
               a = ta[k]; b = tbv[k];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("stream_results", 32'(r), 32'd3);
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
